// File: rtl/harness_pkg.sv
// harness_pkg: shared opcodes, status codes, states and packet layout for the delay-line harness
package harness_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ = 8'h02;
  localparam logic [7:0] OP_RUN = 8'h03;
  localparam logic [7:0] OP_PING = 8'h04;
  localparam logic [7:0] ST_OK = 8'h00;
  localparam logic [7:0] ST_BAD_OP = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam int OP_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 16;
  localparam int RESP_LEN = 4;
  typedef enum logic [2:0] {IDLE, DECODE, WR, MEAS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {S_IDLE, S_TX, S_GUARD, S_WAITB} ser_t;
  function automatic logic [31:0] resp_word(logic [7:0] status, logic [7:0] op, logic [15:0] rdata);
    return {rdata, op, status};
  endfunction
endpackage

// File: rtl/resp_ser.sv
// resp_ser: sends a 32-bit response LSB byte first under the tx_valid/tx_busy handshake
module resp_ser
  import harness_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);
  ser_t st;
  logic [31:0] sh;
  logic [31:0] src;
  logic [2:0] cnt;
  logic send;
  always_comb begin
    src = st == S_IDLE ? word : sh;
    done = st == S_WAITB && !tx_busy && cnt == 3'(RESP_LEN);
    send = !tx_busy && ((st == S_IDLE && start) || (st == S_WAITB && cnt != 3'(RESP_LEN)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_IDLE;
      sh <= '0;
      cnt <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= send;
      if (send) tx_data <= src[7:0];
      sh <= send ? {8'h00, src[31:8]} : (st == S_IDLE && start) ? word : sh;
      cnt <= (st == S_IDLE ? 3'd0 : cnt) + 3'(send);
      st <= send ? S_TX : st == S_TX ? S_GUARD : st == S_GUARD ? S_WAITB :
            done ? S_IDLE : (st == S_IDLE && start) ? S_WAITB : st;
    end
  end
endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: pops host command packets, runs config/measurement actions and returns 4-byte responses
module cmd_sched
  import harness_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [7:0]        cfg_addr,
  output logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_wr_en,
  input  logic [DATA_W-1:0] cfg_rd_data,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic [DATA_W-1:0] meas_result,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t st;
  logic [31:0] cmd;
  logic [31:0] resp;
  logic [CW-1:0] cnt;
  logic [7:0] op;
  logic ser_start;
  logic ser_done;
  assign op = cmd[OP_LSB +: 8];
  assign cfg_addr = cmd[ADDR_LSB +: 8];
  assign cfg_wr_data = cmd[DATA_LSB +: DATA_W];
  assign fifo_rd_en = st == IDLE && !fifo_empty && !reset;
  assign cfg_wr_en = st == WR;
  assign meas_start = st == MEAS;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cmd <= '0;
      resp <= '0;
      cnt <= '0;
      ser_start <= 1'b0;
    end else begin
      ser_start <= 1'b0;
      case (st)
        IDLE: if (!fifo_empty) begin
          cmd <= fifo_data;
          st <= DECODE;
        end
        DECODE: begin
          st <= op == OP_WRITE ? WR : op == OP_RUN ? MEAS : RESP;
          if (op != OP_RUN) begin
            ser_start <= 1'b1;
            resp <= resp_word(op inside {OP_WRITE, OP_READ, OP_PING} ? ST_OK : ST_BAD_OP, op,
                              op == OP_READ ? cfg_rd_data : '0);
          end
        end
        WR: st <= RESP;
        MEAS: begin
          cnt <= '0;
          st <= WAIT;
        end
        WAIT: if (meas_done || cnt == LAST) begin
          st <= RESP;
          ser_start <= 1'b1;
          resp <= resp_word(meas_done ? ST_OK : ST_TIMEOUT, op, meas_done ? meas_result : '0);
        end else cnt <= cnt + 1'b1;
        RESP: if (ser_done) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
  resp_ser u_ser (
    .clk(clk),
    .reset(reset),
    .start(ser_start),
    .word(resp),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .done(ser_done)
  );
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: table, hand-written and random command checks of cmd_sched against a packet-level model
module tb_cmd_sched;
  localparam int TO = 16;
  typedef struct {
    logic [31:0] pkt;
    int delay;
    logic [15:0] res;
    int busy;
    logic [7:0] paddr;
    logic [15:0] pval;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] fifo_data = '0;
  logic fifo_empty = 1'b1;
  logic fifo_rd_en;
  logic [7:0] cfg_addr;
  logic [15:0] cfg_wr_data;
  logic cfg_wr_en;
  logic [15:0] cfg_rd_data;
  logic meas_start;
  logic meas_done = 1'b0;
  logic [15:0] meas_result = '0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_busy = 1'b0;
  logic [15:0] cfg_mem [256];
  logic [15:0] mm [256];
  logic [31:0] fq [$];
  logic [7:0] rx_b [$];
  int rx_c [$];
  int pop_c [$];
  int ms_c [$];
  logic [23:0] wr_q [$];
  int cyc = 0;
  int busy_len = 1;
  int busy_left = 0;
  int meas_delay = 0;
  int done_at = -1;
  logic [15:0] meas_val = '0;
  int n_tests = 0;
  int n_fail = 0;
  vec_t v [15];
  always #5 clk = ~clk;
  assign cfg_rd_data = cfg_mem[cfg_addr];
  cmd_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_wr_en(cfg_wr_en),
    .cfg_rd_data(cfg_rd_data),
    .meas_start(meas_start),
    .meas_done(meas_done),
    .meas_result(meas_result),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_busy(tx_busy)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model(logic [31:0] pkt, int delay, logic [15:0] res);
    logic [7:0] op = pkt[7:0];
    logic [7:0] a = pkt[15:8];
    if (op == 8'h01) begin
      mm[a] = pkt[31:16];
      return {16'h0, op, 8'h00};
    end
    if (op == 8'h02) return {mm[a], op, 8'h00};
    if (op == 8'h03) return (delay >= 1 && delay <= TO) ? {res, op, 8'h00} : {16'h0, op, 8'h02};
    if (op == 8'h04) return {16'h0, op, 8'h00};
    return {16'h0, op, 8'h01};
  endfunction
  function automatic logic [7:0] byte_at(int i);
    return rx_b.size() > i ? rx_b[i] : 8'hxx;
  endfunction
  function automatic logic [31:0] word_at(int base);
    return {byte_at(base + 3), byte_at(base + 2), byte_at(base + 1), byte_at(base)};
  endfunction
  task automatic refresh();
    fifo_empty = fq.size() == 0;
    fifo_data = fifo_empty ? $urandom : fq[0];
  endtask
  task automatic push(logic [31:0] p);
    fq.push_back(p);
    refresh();
  endtask
  task automatic clear();
    rx_b.delete();
    rx_c.delete();
    pop_c.delete();
    ms_c.delete();
    wr_q.delete();
  endtask
  task automatic step();
    logic pop, sv, wr;
    logic [7:0] wa;
    logic [15:0] wd;
    @(negedge clk);
    cyc++;
    pop = fifo_rd_en;
    sv = tx_valid;
    wr = cfg_wr_en;
    wa = cfg_addr;
    wd = cfg_wr_data;
    if (tx_valid) begin
      chk("tx_overlap", 32'(tx_busy), 0);
      rx_b.push_back(tx_data);
      rx_c.push_back(cyc);
    end
    if (fifo_rd_en) pop_c.push_back(cyc);
    if (cfg_wr_en) wr_q.push_back({cfg_addr, cfg_wr_data});
    if (meas_start) begin
      ms_c.push_back(cyc);
      done_at = meas_delay > 0 ? cyc + meas_delay : -1;
    end
    @(posedge clk);
    #1;
    if (pop && fq.size() > 0) void'(fq.pop_front());
    if (wr) cfg_mem[wa] = wd;
    if (sv) busy_left = busy_len;
    tx_busy = busy_left > 0;
    if (busy_left > 0) busy_left--;
    meas_done = cyc + 1 == done_at;
    meas_result = meas_done ? meas_val : 16'($urandom);
    refresh();
  endtask
  task automatic drain(int n);
    int b = 0;
    while ((rx_b.size() < n || tx_busy) && b < 3000) begin
      step();
      b++;
    end
    chk("drain_timeout", 32'(b >= 3000), 0);
    repeat (3) step();
  endtask
  task automatic run_one(string name, logic [31:0] pkt, int delay, logic [15:0] res, int busy, logic [31:0] exp);
    logic [7:0] op = pkt[7:0];
    clear();
    meas_delay = delay;
    meas_val = res;
    busy_len = busy;
    push(pkt);
    drain(4);
    chk({name, "_resp"}, word_at(0), exp);
    chk({name, "_nbytes"}, rx_b.size(), 4);
    chk({name, "_pops"}, pop_c.size(), 1);
    chk({name, "_wr_cnt"}, wr_q.size(), 32'(op == 8'h01));
    if (op == 8'h01 && wr_q.size() == 1) chk({name, "_wr"}, 32'(wr_q[0]), 32'({pkt[15:8], pkt[31:16]}));
    chk({name, "_meas_cnt"}, ms_c.size(), 32'(op == 8'h03));
    if (op != 8'h03 && pop_c.size() > 0 && rx_c.size() > 0) chk({name, "_latency"}, rx_c[0] - pop_c[0], 3);
  endtask
  initial begin
    logic [31:0] exp, pkt;
    int b;
    for (int i = 0; i < 256; i++) begin
      cfg_mem[i] = '0;
      mm[i] = '0;
    end
    v[0] = '{32'h1234_0501, 0, 16'h0, 1, 8'hFE, 16'h0, 32'h0000_0100};
    v[1] = '{32'h0000_0502, 0, 16'h0, 1, 8'h05, 16'hBEEF, 32'hBEEF_0200};
    v[2] = '{32'hCAFE_0901, 0, 16'h0, 2, 8'hFE, 16'h0, 32'h0000_0100};
    v[3] = '{32'h0000_0902, 0, 16'h0, 1, 8'hFE, 16'h0, 32'hCAFE_0200};
    v[4] = '{32'h0000_0003, 10, 16'h00A5, 1, 8'hFE, 16'h0, 32'h00A5_0300};
    v[5] = '{32'h0000_0003, 1, 16'h5A5A, 1, 8'hFE, 16'h0, 32'h5A5A_0300};
    v[6] = '{32'h0000_0003, 16, 16'h1357, 1, 8'hFE, 16'h0, 32'h1357_0300};
    v[7] = '{32'h0000_0003, 17, 16'h2468, 1, 8'hFE, 16'h0, 32'h0000_0302};
    v[8] = '{32'h0000_0003, 0, 16'h0, 1, 8'hFE, 16'h0, 32'h0000_0302};
    v[9] = '{32'h0000_007F, 0, 16'h0, 1, 8'hFE, 16'h0, 32'h0000_7F01};
    v[10] = '{32'hFFFF_FF04, 0, 16'h0, 1, 8'hFE, 16'h0, 32'h0000_0400};
    v[11] = '{32'h0000_0000, 0, 16'h0, 3, 8'hFE, 16'h0, 32'h0000_0001};
    v[12] = '{32'hFFFF_FF01, 0, 16'h0, 2, 8'hFE, 16'h0, 32'h0000_0100};
    v[13] = '{32'h0000_FF02, 0, 16'h0, 1, 8'hFE, 16'h0, 32'hFFFF_0200};
    v[14] = '{32'h0000_0003, 5, 16'hABCD, 10, 8'hFE, 16'h0, 32'hABCD_0300};
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("reset_cfg", {cfg_addr, cfg_wr_data}, 0);
    chk("reset_ctl", {fifo_rd_en, cfg_wr_en, meas_start, tx_valid, tx_data}, 0);
    foreach (v[i]) begin
      cfg_mem[v[i].paddr] = v[i].pval;
      mm[v[i].paddr] = v[i].pval;
      void'(model(v[i].pkt, v[i].delay, v[i].res));
      run_one($sformatf("v%0d", i), v[i].pkt, v[i].delay, v[i].res, v[i].busy, v[i].exp);
    end
    clear();
    busy_len = 10;
    meas_delay = 0;
    push(32'h0000_007F);
    push(32'h0000_0004);
    drain(8);
    chk("q_resp0", word_at(0), 32'h0000_7F01);
    chk("q_resp1", word_at(4), 32'h0000_0400);
    chk("q_nbytes", rx_b.size(), 8);
    chk("q_pops", pop_c.size(), 2);
    if (pop_c.size() == 2 && rx_c.size() >= 4) chk("q_pop_after_resp", 32'(pop_c[1] > rx_c[3]), 1);
    for (int i = 0; i + 1 < rx_c.size(); i++) chk("q_byte_gap", 32'(rx_c[i + 1] - rx_c[i] > 10), 1);
    clear();
    busy_len = 5;
    push(32'h0000_0004);
    b = 0;
    while (rx_b.size() < 2 && b < 200) begin
      step();
      b++;
    end
    chk("rst_reach_byte2", 32'(b >= 200), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_mid_cfg", {cfg_addr, cfg_wr_data}, 0);
    chk("rst_mid_ctl", {fifo_rd_en, cfg_wr_en, meas_start, tx_valid, tx_data}, 0);
    repeat (30) step();
    chk("rst_no_more_tx", rx_b.size(), 2);
    push(32'h0000_0004);
    drain(6);
    chk("rst_next_resp", word_at(2), 32'h0000_0400);
    chk("rst_next_nbytes", rx_b.size(), 6);
    for (int n = 0; n < 40; n++) begin
      int sel, delay;
      logic [15:0] res;
      sel = $urandom_range(0, 5);
      pkt = $urandom;
      pkt[15:8] = 8'($urandom_range(0, 15));
      pkt[7:0] = sel == 0 ? 8'h01 : sel == 1 ? 8'h02 : sel == 2 ? 8'h03 : sel == 3 ? 8'h04 :
                 sel == 4 ? 8'($urandom) : 8'($urandom_range(1, 2));
      delay = $urandom_range(0, 19);
      res = 16'($urandom);
      exp = model(pkt, delay, res);
      run_one($sformatf("r%0d", n), pkt, delay, res, $urandom_range(1, 4), exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
